// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath strobes combinationally from the current state and opcode.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] instruction,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_wren,
  output logic [1:0] pc_src,
  output logic       ir_wren,
  output logic       reg_file_wren,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src,
  output logic [2:0] alu_control,
  output logic       data_mem_rden,
  output logic       data_mem_wren,
  output logic       instr_done,
  output logic       mem_err,
  output logic [2:0] state
);

  localparam int unsigned WAIT_W = 8;

  localparam logic [3:0] OP_MOVE = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_NOT  = 4'h3;
  localparam logic [3:0] OP_NOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_JAL  = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_ADDI = 4'hE;
  localparam logic [3:0] OP_LI   = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5
  } state_t;

  state_t              cur, nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                timeout_c;
  logic                end_c;
  logic [3:0]          opcode;
  logic                is_lw;
  logic                instr_unused;

  assign opcode       = instruction[7:4];
  assign is_lw        = (opcode == OP_LW);
  assign instr_unused = ^instruction[3:0];
  assign state        = cur;

  // State, memory wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= S_IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur != S_MEMORY)
        wait_cnt <= '0;
      else if (!mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (timeout_c)
        mem_err <= 1'b1;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    nxt           = cur;
    pc_wren       = 1'b0;
    pc_src        = 2'b00;
    ir_wren       = 1'b0;
    reg_file_wren = 1'b0;
    wb_sel        = 2'b00;
    alu_src       = 2'b00;
    alu_control   = 3'b000;
    data_mem_rden = 1'b0;
    data_mem_wren = 1'b0;
    instr_done    = 1'b0;
    timeout_c     = 1'b0;
    end_c         = 1'b0;

    case (cur)
      S_IDLE: if (run) nxt = S_FETCH;
      S_FETCH: begin
        ir_wren = 1'b1;
        pc_wren = 1'b1;
        nxt     = S_DECODE;
      end
      S_DECODE: nxt = S_EXECUTE;
      S_EXECUTE: begin
        case (opcode)
          OP_MOVE: begin alu_src = 2'b10; nxt = S_WRITEBACK; end
          OP_ADD:  nxt = S_WRITEBACK;
          OP_AND:  begin alu_control = 3'b001; nxt = S_WRITEBACK; end
          OP_NOT:  begin alu_control = 3'b010; nxt = S_WRITEBACK; end
          OP_NOR:  begin alu_control = 3'b011; nxt = S_WRITEBACK; end
          OP_SLT:  begin alu_control = 3'b101; nxt = S_WRITEBACK; end
          OP_SLL:  begin alu_control = 3'b110; alu_src = 2'b01; nxt = S_WRITEBACK; end
          OP_SRL:  begin alu_control = 3'b111; alu_src = 2'b01; nxt = S_WRITEBACK; end
          OP_ADDI, OP_LI: begin alu_src = 2'b01; nxt = S_WRITEBACK; end
          OP_LW, OP_SW:   begin alu_src = 2'b01; nxt = S_MEMORY; end
          OP_BEQ, OP_BNE: begin
            alu_control = 3'b100;
            pc_src      = 2'b01;
            pc_wren     = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;
            end_c       = 1'b1;
          end
          OP_J: begin
            pc_wren = 1'b1;
            pc_src  = 2'b10;
            end_c   = 1'b1;
          end
          OP_JAL: begin
            pc_wren       = 1'b1;
            pc_src        = 2'b10;
            reg_file_wren = 1'b1;
            wb_sel        = 2'b11;
            end_c         = 1'b1;
          end
        endcase
      end
      S_MEMORY: begin
        if (mem_ready) begin
          data_mem_rden = is_lw;
          data_mem_wren = ~is_lw;
          if (is_lw) nxt = S_WRITEBACK;
          else       end_c = 1'b1;
        end else if (wait_cnt == {WAIT_W{1'b1}}) begin
          // Memory never answered: abandon the access without completing it
          timeout_c = 1'b1;
          nxt       = S_IDLE;
        end else begin
          data_mem_rden = is_lw;
          data_mem_wren = ~is_lw;
        end
      end
      S_WRITEBACK: begin
        reg_file_wren = 1'b1;
        if (is_lw)                wb_sel = 2'b01;
        else if (opcode == OP_LI) wb_sel = 2'b10;
        end_c = 1'b1;
      end
      default: nxt = S_IDLE;
    endcase

    if (end_c) begin
      instr_done = 1'b1;
      nxt        = run ? S_FETCH : S_IDLE;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller, plus hand-written
// sequences for the memory timeout and reset-in-MEMORY corners.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst, run, alu_zero, mem_ready;
  logic [7:0] instruction;
  logic       pc_wren, ir_wren, reg_file_wren, data_mem_rden, data_mem_wren;
  logic       instr_done, mem_err;
  logic [1:0] pc_src, wb_sel, alu_src;
  logic [2:0] alu_control, state;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .run(run), .instruction(instruction),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_wren(pc_wren), .pc_src(pc_src), .ir_wren(ir_wren),
    .reg_file_wren(reg_file_wren), .wb_sel(wb_sel), .alu_src(alu_src),
    .alu_control(alu_control), .data_mem_rden(data_mem_rden),
    .data_mem_wren(data_mem_wren), .instr_done(instr_done),
    .mem_err(mem_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        run;
    logic [7:0]  instr;
    logic        az;
    logic        mr;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [18:0] act;
  assign act = {state, pc_wren, pc_src, ir_wren, reg_file_wren, wb_sel, alu_src,
                alu_control, data_mem_rden, data_mem_wren, instr_done, mem_err};

  function automatic logic [18:0] o(input int st, input int pcw, input int pcs,
                                    input int irw, input int rfw, input int wbs,
                                    input int asr, input int actl, input int rd,
                                    input int wr, input int dn, input int me);
    return {3'(st), 1'(pcw), 2'(pcs), 1'(irw), 1'(rfw), 2'(wbs), 2'(asr),
            3'(actl), 1'(rd), 1'(wr), 1'(dn), 1'(me)};
  endfunction

  logic [18:0] e_idle, e_fetch, e_dec;
  initial begin
    e_idle  = o(0,0,0,0,0,0,0,0,0,0,0,0);
    e_fetch = o(1,1,0,1,0,0,0,0,0,0,0,0);
    e_dec   = o(2,0,0,0,0,0,0,0,0,0,0,0);
  end

  task automatic add(input logic r, input logic [7:0] ins, input logic az,
                     input logic mr, input logic [18:0] e);
    vec_t v;
    v.run = r; v.instr = ins; v.az = az; v.mr = mr; v.exp = e;
    tbl.push_back(v);
  endtask

  // Four-cycle ALU instruction with run held high
  task automatic alu_seq(input logic [7:0] ins, input int asr, input int actl, input int wbs);
    add(1, ins, 0, 0, e_fetch);
    add(1, ins, 0, 0, e_dec);
    add(1, ins, 0, 0, o(3,0,0,0,0,0,asr,actl,0,0,0,0));
    add(1, ins, 0, 0, o(5,0,0,0,1,wbs,0,0,0,0,1,0));
  endtask

  task automatic three_seq(input logic [7:0] ins, input logic az, input logic [18:0] ex);
    add(1, ins, az, 0, e_fetch);
    add(1, ins, az, 0, e_dec);
    add(1, ins, az, 0, ex);
  endtask

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  int n, mem_cycles;
  logic seen_done;

  initial begin
    rst = 1'b1; run = 1'b0; instruction = 8'h00; alu_zero = 1'b0; mem_ready = 1'b0;

    add(0, 8'h00, 0, 0, e_idle);
    add(1, 8'h10, 0, 0, e_idle);
    alu_seq(8'h10, 0, 0, 0);
    alu_seq(8'h40, 0, 3, 0);
    alu_seq(8'h20, 0, 1, 0);
    alu_seq(8'h30, 0, 2, 0);
    alu_seq(8'h60, 1, 6, 0);
    alu_seq(8'h00, 2, 0, 0);
    alu_seq(8'h5F, 0, 5, 0);
    alu_seq(8'h73, 1, 7, 0);
    alu_seq(8'hE1, 1, 0, 0);
    alu_seq(8'hF5, 1, 0, 2);
    three_seq(8'hC0, 1, o(3,1,1,0,0,0,0,4,0,0,1,0));
    three_seq(8'hC0, 0, o(3,0,1,0,0,0,0,4,0,0,1,0));
    three_seq(8'hD0, 1, o(3,0,1,0,0,0,0,4,0,0,1,0));
    three_seq(8'hD0, 0, o(3,1,1,0,0,0,0,4,0,0,1,0));
    three_seq(8'h9A, 0, o(3,1,2,0,1,3,0,0,0,0,1,0));
    three_seq(8'h80, 0, o(3,1,2,0,0,0,0,0,0,0,1,0));
    // lw with three wait cycles
    three_seq(8'hA0, 0, o(3,0,0,0,0,0,1,0,0,0,0,0));
    for (int i = 0; i < 3; i++) add(1, 8'hA0, 0, 0, o(4,0,0,0,0,0,0,0,1,0,0,0));
    add(1, 8'hA0, 0, 1, o(4,0,0,0,0,0,0,0,1,0,0,0));
    add(1, 8'hA0, 0, 0, o(5,0,0,0,1,1,0,0,0,0,1,0));
    // sw with one wait, run dropped in its final cycle
    three_seq(8'hB0, 0, o(3,0,0,0,0,0,1,0,0,0,0,0));
    add(1, 8'hB0, 0, 0, o(4,0,0,0,0,0,0,0,0,1,0,0));
    add(0, 8'hB0, 0, 1, o(4,0,0,0,0,0,0,0,0,1,1,0));
    add(0, 8'hB0, 0, 0, e_idle);
    // run dropped during DECODE of add
    add(1, 8'h10, 0, 0, e_idle);
    add(1, 8'h10, 0, 0, e_fetch);
    add(0, 8'h10, 0, 0, e_dec);
    add(0, 8'h10, 0, 0, o(3,0,0,0,0,0,0,0,0,0,0,0));
    add(0, 8'h10, 0, 0, o(5,0,0,0,1,0,0,0,0,0,1,0));
    add(0, 8'h10, 0, 0, e_idle);
    add(0, 8'h10, 0, 0, e_idle);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      if (i != 0) @(negedge clk);
      run = tbl[i].run; instruction = tbl[i].instr;
      alu_zero = tbl[i].az; mem_ready = tbl[i].mr;
      #1;
      chk($sformatf("vec%0d", i), 32'(act), 32'(tbl[i].exp));
    end

    // sw that never gets mem_ready: timeout after 256 MEMORY cycles
    @(negedge clk);
    run = 1'b1; instruction = 8'hB0; mem_ready = 1'b0; #1;
    chk("to_idle", 32'(state), 32'd0);
    @(negedge clk);
    run = 1'b0; #1;
    chk("to_fetch", 32'(state), 32'd1);
    n = 0;
    while (state != 3'd4 && n < 10) begin @(negedge clk); #1; n++; end
    chk("to_reach_mem", 32'(state), 32'd4);
    mem_cycles = 0; seen_done = 1'b0;
    while (state == 3'd4 && mem_cycles < 300) begin
      if (instr_done) seen_done = 1'b1;
      if (mem_cycles == 0) chk("to_wren_on", 32'(data_mem_wren), 32'd1);
      mem_cycles++;
      @(negedge clk); #1;
    end
    chk("to_mem_cycles", 32'(mem_cycles), 32'd256);
    chk("to_state_idle", 32'(state), 32'd0);
    chk("to_mem_err", 32'(mem_err), 32'd1);
    chk("to_wren_off", 32'(data_mem_wren), 32'd0);
    chk("to_no_done", 32'(seen_done), 32'd0);

    // restart with mem_err still set, then reset during a lw MEMORY wait
    run = 1'b1; instruction = 8'hA0;
    @(negedge clk); #1;
    chk("rs_fetch", 32'(state), 32'd1);
    chk("rs_ir_wren", 32'(ir_wren), 32'd1);
    chk("rs_err_sticky", 32'(mem_err), 32'd1);
    run = 1'b0;
    n = 0;
    while (state != 3'd4 && n < 10) begin @(negedge clk); #1; n++; end
    chk("rm_reach_mem", 32'(state), 32'd4);
    chk("rm_rden_on", 32'(data_mem_rden), 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rm_state", 32'(state), 32'd0);
    chk("rm_rden_off", 32'(data_mem_rden), 32'd0);
    chk("rm_err_clr", 32'(mem_err), 32'd0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
